multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Control unit for the multi-cycle RISC-V core: a Moore state machine plus opcode/ALU decoders that drive every select and write-enable of the multi-cycle datapath. It consumes the latched instruction fields and the ALU flags (Zero, SF) from the datapath. Each cycle it produces ResultSrc, ALUSrcA/B, RegWrite, PCWrite, IRWrite, ImmSrc, ALUControl, AdrSrc, and the memory write strobe.

## Interface
- No parameters.
- clk  in  1  core clock; all state changes on rising edge
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- op  in  7  Instr[6:0]
- funct3  in  3  Instr[14:12]
- funct7b5  in  1  Instr[30]
- Zero  in  1  ALU result == 0
- SF  in  1  ALU result sign bit
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 A, 11 zero
- ALUSrcB  out  2  00 WriteData, 01 ImmExt, 10 constant 4
- RegWrite, PCWrite, IRWrite, MemWrite  out  1 each  write enables
- AdrSrc  out  1  0 PC, 1 Result
- ImmSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sll, 111 srl
- Illegal  out  1  one-cycle pulse in DECODE on unsupported opcode
- state  out  4  current state, debug

## Operation
- Internal: PCUpdate, Branch, ALUOp[1:0] (00 add, 01 sub, 10 funct-decoded). PCWrite = PCUpdate | (Branch & taken).
- States and encodings, with unlisted outputs at 0 or 00:
- FETCH=0: AdrSrc=0, IRWrite, A=PC, B=4, add, ResultSrc=10, PCUpdate -> DECODE.
- DECODE=1: A=OldPC, B=Imm, add; ALUOut becomes the branch/jal target.
  - 0000011/0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR
  - 0110111 -> LUI
  - any other opcode -> FETCH with Illegal=1
- MEMADR=2: A=A, B=Imm, add. Next is MEMREAD if op[5]=0, else MEMWRITE.
- MEMREAD=3: ResultSrc=00, AdrSrc=1 -> MEMWB.
- MEMWB=4: ResultSrc=01, RegWrite -> FETCH.
- MEMWRITE=5: ResultSrc=00, AdrSrc=1, MemWrite -> FETCH.
- EXECR=6: A=A, B=WriteData, ALUOp=10 -> ALUWB.
- EXECI=7: A=A, B=Imm, ALUOp=10 -> ALUWB.
- ALUWB=8: ResultSrc=00, RegWrite -> FETCH.
- BRANCH=9: A=A, B=WriteData, sub, ResultSrc=00, Branch -> FETCH.
- JAL=10: A=OldPC, B=4, add, ResultSrc=00, PCUpdate -> ALUWB.
- JALR=11: A=A, B=Imm, add, ResultSrc=10, PCUpdate -> JALRLINK.
- JALRLINK=12: A=OldPC, B=4, add -> ALUWB.
- LUI=13: A=zero, B=Imm, add -> ALUWB.
- Codes 14 and 15 are unreachable; if entered, go to FETCH with all enables 0.
- Branch taken rule:
  - funct3 000: Zero
  - funct3 001: !Zero
  - funct3 100: SF
  - funct3 101: !SF
  - any other funct3: not taken
  - SF is the raw difference sign; signed overflow is ignored by design.
- ImmSrc is decoded combinationally from op in every state:
  - loads, I-ALU and jalr -> I
  - store -> S
  - branch -> B
  - jal -> J
  - lui -> U
  - anything else -> I
- ALU decoder, applied when ALUOp=10, selected by funct3:
  - 000: sub if op[5]&funct7b5, else add
  - 001: sll
  - 010: slt
  - 011: add
  - 100: xor
  - 101: srl
  - 110: or
  - 111: and

## Timing
- Outputs are combinational from the state register plus op/funct/flags; there are no registered outputs.
- While reset=1: state<=FETCH at the edge, and RegWrite, PCWrite, IRWrite, MemWrite and Illegal are forced to 0. The first FETCH is the first cycle after reset deasserts.
- Reset asserted in any state aborts the instruction; no write enable is asserted in that cycle.
- CPI:
  - lw 5
  - sw 4
  - R, I, lui 4
  - jal 4
  - jalr 5
  - branch 3
  - illegal 2
- op/funct are sampled only from DECODE onward (Instr is latched at the end of FETCH).
- Branch PCWrite depends on the same-cycle Zero/SF, so there is a combinational path from flags to PCWrite.

## Test plan
- Reset held 3 cycles, then released -> state=0, all enables 0 during reset; the first post-reset cycle has IRWrite=1, PCWrite=1, ALUSrcB=10.
- lw (op 0000011) -> states 0,1,2,3,4,0; MEMREAD has AdrSrc=1; MEMWB has ResultSrc=01, RegWrite=1. sw (0100011) -> 0,1,2,5,0 with MemWrite=1 only in state 5.
- R-type sub (funct3 000, funct7b5 1) -> EXECR ALUControl=001, then ALUWB RegWrite=1. I-type addi with funct7b5=1 -> ALUControl=000.
- Branches with funct3=000 (beq):
  - Zero=1 -> BRANCH PCWrite=1, ALUControl=001.
  - Zero=0 -> PCWrite=0.
- bge (funct3 101) with SF=1 -> PCWrite=0; with SF=0 -> PCWrite=1.
- Jumps:
  - jal -> 0,1,10,8 with PCWrite=1 in state 10, RegWrite=1 in state 8.
  - jalr -> 0,1,11,12,8.
  - op 1111111 -> Illegal=1 for one cycle, back to FETCH, no writes.

Source files
------------

// File: rtl/multicycle_controller.sv
// multicycle_controller
// Control unit for the multi-cycle RISC-V core. A Moore FSM sequences each
// instruction through its datapath steps while combinational opcode and ALU
// decoders drive every datapath select and write enable.
//
// Ports:
//   clk        in   core clock, rising-edge
//   reset      in   synchronous, active-high
//   op         in   Instr[6:0]
//   funct3     in   Instr[14:12]
//   funct7b5   in   Instr[30]
//   Zero, SF   in   ALU flags (result == 0, result sign)
//   ResultSrc  out  00 ALUOut, 01 Data, 10 ALUResult
//   ALUSrcA    out  00 PC, 01 OldPC, 10 A, 11 zero
//   ALUSrcB    out  00 WriteData, 01 ImmExt, 10 constant 4
//   RegWrite, PCWrite, IRWrite, MemWrite  out  write enables
//   AdrSrc     out  0 PC, 1 Result
//   ImmSrc     out  000 I, 001 S, 010 B, 011 J, 100 U
//   ALUControl out  000 add, 001 sub, 010 and, 011 or, 100 xor,
//                   101 slt, 110 sll, 111 srl
//   Illegal    out  pulse in DECODE on an unsupported opcode
//   state      out  current FSM state (debug)
module multicycle_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       SF,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       RegWrite,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic [2:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       Illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_JALRLINK = 4'd12,
        S_LUI      = 4'd13
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic       w_pc_update;
    logic       w_branch;
    logic       w_taken;
    logic [1:0] w_alu_op;
    logic       w_reg_write;
    logic       w_ir_write;
    logic       w_mem_write;
    logic       w_illegal;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_next;
    end

    assign state = r_state;

    always_comb begin
        w_next      = S_FETCH;
        w_pc_update = 1'b0;
        w_branch    = 1'b0;
        w_alu_op    = 2'b00;
        w_reg_write = 1'b0;
        w_ir_write  = 1'b0;
        w_mem_write = 1'b0;
        w_illegal   = 1'b0;
        ResultSrc   = 2'b00;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        AdrSrc      = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_ir_write  = 1'b1;
                ALUSrcB     = 2'b10;
                ResultSrc   = 2'b10;
                w_pc_update = 1'b1;
                w_next      = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    7'b0000011,
                    7'b0100011: w_next = S_MEMADR;
                    7'b0110011: w_next = S_EXECR;
                    7'b0010011: w_next = S_EXECI;
                    7'b1100011: w_next = S_BRANCH;
                    7'b1101111: w_next = S_JAL;
                    7'b1100111: w_next = S_JALR;
                    7'b0110111: w_next = S_LUI;
                    default: begin
                        w_next    = S_FETCH;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                w_next  = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                w_next = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc   = 2'b01;
                w_reg_write = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc      = 1'b1;
                w_mem_write = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA  = 2'b10;
                w_alu_op = 2'b10;
                w_next   = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA  = 2'b10;
                ALUSrcB  = 2'b01;
                w_alu_op = 2'b10;
                w_next   = S_ALUWB;
            end
            S_ALUWB: w_reg_write = 1'b1;
            S_BRANCH: begin
                ALUSrcA  = 2'b10;
                w_alu_op = 2'b01;
                w_branch = 1'b1;
            end
            S_JAL: begin
                ALUSrcA     = 2'b01;
                ALUSrcB     = 2'b10;
                w_pc_update = 1'b1;
                w_next      = S_ALUWB;
            end
            S_JALR: begin
                ALUSrcA     = 2'b10;
                ALUSrcB     = 2'b01;
                ResultSrc   = 2'b10;
                w_pc_update = 1'b1;
                w_next      = S_JALRLINK;
            end
            S_JALRLINK: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                w_next  = S_ALUWB;
            end
            S_LUI: begin
                ALUSrcA = 2'b11;
                ALUSrcB = 2'b01;
                w_next  = S_ALUWB;
            end
            default: w_next = S_FETCH;
        endcase
    end

    // Branch condition uses same-cycle flags; SF is taken as-is (no overflow fix-up).
    always_comb begin
        case (funct3)
            3'b000:  w_taken = Zero;
            3'b001:  w_taken = ~Zero;
            3'b100:  w_taken = SF;
            3'b101:  w_taken = ~SF;
            default: w_taken = 1'b0;
        endcase
    end

    always_comb begin
        case (op)
            7'b0100011: ImmSrc = 3'b001;
            7'b1100011: ImmSrc = 3'b010;
            7'b1101111: ImmSrc = 3'b011;
            7'b0110111: ImmSrc = 3'b100;
            default:    ImmSrc = 3'b000;
        endcase
    end

    always_comb begin
        case (w_alu_op)
            2'b00: ALUControl = 3'b000;
            2'b01: ALUControl = 3'b001;
            default: begin
                case (funct3)
                    3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
                    3'b001:  ALUControl = 3'b110;
                    3'b010:  ALUControl = 3'b101;
                    3'b011:  ALUControl = 3'b000;
                    3'b100:  ALUControl = 3'b100;
                    3'b101:  ALUControl = 3'b111;
                    3'b110:  ALUControl = 3'b011;
                    default: ALUControl = 3'b010;
                endcase
            end
        endcase
    end

    // Reset masks every enable so an aborted instruction leaves no side effects.
    assign RegWrite = w_reg_write & ~reset;
    assign IRWrite  = w_ir_write  & ~reset;
    assign MemWrite = w_mem_write & ~reset;
    assign Illegal  = w_illegal   & ~reset;
    assign PCWrite  = (w_pc_update | (w_branch & w_taken)) & ~reset;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller
// Scoreboard bench: for each instruction the expected per-cycle output vector
// is pushed when the instruction's inputs are driven, then popped and compared
// against the DUT outputs once per cycle on the falling edge.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       SF;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic       RegWrite, PCWrite, IRWrite, MemWrite, AdrSrc, Illegal;
    logic [2:0] ImmSrc, ALUControl;
    logic [3:0] state;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    logic [21:0] sb_q[$];

    // Per-instruction attributes used when building expected vectors.
    logic [2:0] cur_imm;
    logic [2:0] cur_ac;
    logic       cur_pw;
    logic       cur_ill;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .SF(SF), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .RegWrite(RegWrite), .PCWrite(PCWrite),
        .IRWrite(IRWrite), .MemWrite(MemWrite), .AdrSrc(AdrSrc),
        .ImmSrc(ImmSrc), .ALUControl(ALUControl), .Illegal(Illegal),
        .state(state)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish, vectors=%0d miscompares=%0d", n_vec, n_err);
        $fatal(1, "timeout");
    end

    // Vector layout: {state, RegWrite, PCWrite, IRWrite, MemWrite, Illegal,
    //                 ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, AdrSrc}
    function automatic logic [21:0] obs_vec();
        return {state, RegWrite, PCWrite, IRWrite, MemWrite, Illegal,
                ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, AdrSrc};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected outputs of one state, straight from the state table.
    task automatic push_state(input logic [3:0] st);
        logic [3:0] we;
        logic       ill;
        logic [1:0] rs, sa, sb;
        logic [2:0] ac;
        logic       adr;
        we = 4'b0000; ill = 1'b0; rs = 2'b00; sa = 2'b00; sb = 2'b00;
        ac = 3'b000; adr = 1'b0;
        case (st)
            4'd0:  begin we = 4'b0110; rs = 2'b10; sb = 2'b10; end
            4'd1:  begin sa = 2'b01; sb = 2'b01; ill = cur_ill; end
            4'd2:  begin sa = 2'b10; sb = 2'b01; end
            4'd3:  adr = 1'b1;
            4'd4:  begin rs = 2'b01; we = 4'b1000; end
            4'd5:  begin adr = 1'b1; we = 4'b0001; end
            4'd6:  begin sa = 2'b10; ac = cur_ac; end
            4'd7:  begin sa = 2'b10; sb = 2'b01; ac = cur_ac; end
            4'd8:  we = 4'b1000;
            4'd9:  begin sa = 2'b10; ac = 3'b001; we = {1'b0, cur_pw, 2'b00}; end
            4'd10: begin sa = 2'b01; sb = 2'b10; we = 4'b0100; end
            4'd11: begin sa = 2'b10; sb = 2'b01; rs = 2'b10; we = 4'b0100; end
            4'd12: begin sa = 2'b01; sb = 2'b10; end
            4'd13: begin sa = 2'b11; sb = 2'b01; end
            default: ;
        endcase
        sb_q.push_back({st, we, ill, rs, sa, sb, ac, cur_imm, adr});
    endtask

    // Entered just after a falling edge with the DUT in FETCH.
    task automatic run_instr(input string tag, input logic [6:0] o, input logic [2:0] f3,
                             input logic f7, input logic z, input logic s,
                             input logic [2:0] imm, input logic [2:0] ac,
                             input logic pw, input logic ill, input int unsigned n,
                             input logic [3:0] a0, input logic [3:0] a1,
                             input logic [3:0] a2, input logic [3:0] a3,
                             input logic [3:0] a4);
        logic [3:0]  seq [5];
        logic [21:0] exp;
        op = o; funct3 = f3; funct7b5 = f7; Zero = z; SF = s;
        cur_imm = imm; cur_ac = ac; cur_pw = pw; cur_ill = ill;
        seq[0] = a0; seq[1] = a1; seq[2] = a2; seq[3] = a3; seq[4] = a4;
        for (int i = 0; i < int'(n); i++) push_state(seq[i]);
        for (int i = 0; i < int'(n); i++) begin
            #1;
            if (sb_q.size() == 0) begin
                check_eq({tag, "_sb_empty"}, 32'(i), 32'hFFFF_FFFF);
            end else begin
                exp = sb_q.pop_front();
                check_eq($sformatf("%s_c%0d", tag, i), {10'd0, obs_vec()}, {10'd0, exp});
            end
            @(negedge clk);
        end
    endtask

    logic [2:0] r_ac_tab [8];

    initial begin
        reset = 1'b1; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; Zero = 1'b0; SF = 1'b0;
        cur_imm = 3'b000; cur_ac = 3'b000; cur_pw = 1'b0; cur_ill = 1'b0;
        r_ac_tab[0] = 3'b000; r_ac_tab[1] = 3'b110; r_ac_tab[2] = 3'b101; r_ac_tab[3] = 3'b000;
        r_ac_tab[4] = 3'b100; r_ac_tab[5] = 3'b111; r_ac_tab[6] = 3'b011; r_ac_tab[7] = 3'b010;

        // Reset held for three cycles: FETCH state, all enables masked.
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq($sformatf("rst_state%0d", i), {28'd0, state}, 32'd0);
            check_eq($sformatf("rst_en%0d", i),
                     {27'd0, RegWrite, PCWrite, IRWrite, MemWrite, Illegal}, 32'd0);
            @(negedge clk);
        end
        reset = 1'b0;

        run_instr("lw",   7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 5, 0, 1, 2, 3, 4);
        run_instr("sw",   7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0, 3'b001, 3'b000, 1'b0, 1'b0, 4, 0, 1, 2, 5, 0);
        run_instr("sub",  7'b0110011, 3'b000, 1'b1, 1'b0, 1'b0, 3'b000, 3'b001, 1'b0, 1'b0, 4, 0, 1, 6, 8, 0);
        for (int f = 0; f < 8; f++)
            run_instr($sformatf("rtype_f%0d", f), 7'b0110011, 3'(f), 1'b0, 1'b0, 1'b0,
                      3'b000, r_ac_tab[f], 1'b0, 1'b0, 4, 0, 1, 6, 8, 0);
        run_instr("addi_f7", 7'b0010011, 3'b000, 1'b1, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 4, 0, 1, 7, 8, 0);
        run_instr("srli",    7'b0010011, 3'b101, 1'b1, 1'b0, 1'b0, 3'b000, 3'b111, 1'b0, 1'b0, 4, 0, 1, 7, 8, 0);
        run_instr("beq_t",   7'b1100011, 3'b000, 1'b0, 1'b1, 1'b0, 3'b010, 3'b000, 1'b1, 1'b0, 3, 0, 1, 9, 0, 0);
        run_instr("beq_n",   7'b1100011, 3'b000, 1'b0, 1'b0, 1'b0, 3'b010, 3'b000, 1'b0, 1'b0, 3, 0, 1, 9, 0, 0);
        run_instr("bne_t",   7'b1100011, 3'b001, 1'b0, 1'b0, 1'b0, 3'b010, 3'b000, 1'b1, 1'b0, 3, 0, 1, 9, 0, 0);
        run_instr("bne_n",   7'b1100011, 3'b001, 1'b0, 1'b1, 1'b0, 3'b010, 3'b000, 1'b0, 1'b0, 3, 0, 1, 9, 0, 0);
        run_instr("blt_t",   7'b1100011, 3'b100, 1'b0, 1'b0, 1'b1, 3'b010, 3'b000, 1'b1, 1'b0, 3, 0, 1, 9, 0, 0);
        run_instr("bge_n",   7'b1100011, 3'b101, 1'b0, 1'b0, 1'b1, 3'b010, 3'b000, 1'b0, 1'b0, 3, 0, 1, 9, 0, 0);
        run_instr("bge_t",   7'b1100011, 3'b101, 1'b0, 1'b0, 1'b0, 3'b010, 3'b000, 1'b1, 1'b0, 3, 0, 1, 9, 0, 0);
        run_instr("bf3_010", 7'b1100011, 3'b010, 1'b0, 1'b1, 1'b1, 3'b010, 3'b000, 1'b0, 1'b0, 3, 0, 1, 9, 0, 0);
        run_instr("jal",     7'b1101111, 3'b000, 1'b0, 1'b0, 1'b0, 3'b011, 3'b000, 1'b0, 1'b0, 4, 0, 1, 10, 8, 0);
        run_instr("jalr",    7'b1100111, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 5, 0, 1, 11, 12, 8);
        run_instr("lui",     7'b0110111, 3'b000, 1'b0, 1'b0, 1'b0, 3'b100, 3'b000, 1'b0, 1'b0, 4, 0, 1, 13, 8, 0);
        run_instr("illegal", 7'b1111111, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b1, 2, 0, 1, 0, 0, 0);
        run_instr("after_ill", 7'b0110111, 3'b000, 1'b0, 1'b0, 1'b0, 3'b100, 3'b000, 1'b0, 1'b0, 4, 0, 1, 13, 8, 0);

        // Reset during MEMWB of a load: RegWrite must be masked, FSM returns to FETCH.
        run_instr("lw_abort", 7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 4, 0, 1, 2, 3, 0);
        reset = 1'b1;
        #1;
        check_eq("abort_state", {28'd0, state}, 32'd4);
        check_eq("abort_en", {27'd0, RegWrite, PCWrite, IRWrite, MemWrite, Illegal}, 32'd0);
        @(negedge clk);
        #1;
        check_eq("abort_fetch", {28'd0, state}, 32'd0);
        check_eq("abort_fetch_en", {27'd0, RegWrite, PCWrite, IRWrite, MemWrite, Illegal}, 32'd0);
        reset = 1'b0;
        run_instr("post_abort_sw", 7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0, 3'b001, 3'b000, 1'b0, 1'b0, 4, 0, 1, 2, 5, 0);

        check_eq("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
